// File: rtl/if_id_buf.sv
// IF/ID decoupling queue: buffers fetched instructions with their PC+4 so fetch
// can run ahead of a stalled decode; a flush empties it in a single cycle.
module if_id_buf #(
   parameter int               INS_W = 32,
   parameter int               PC_W  = 30,
   parameter int               DEPTH = 4,
   parameter logic [INS_W-1:0] NOP   = '0
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   if_valid,
   output logic                   if_ready,
   input  logic [INS_W-1:0]       if_ins,
   input  logic [PC_W-1:0]        PC_plus_4,
   input  logic                   flush,
   input  logic                   hazard,
   output logic [INS_W-1:0]       id_ins,
   output logic [PC_W-1:0]        id_PC_plus_4,
   output logic                   id_valid,
   output logic [$clog2(DEPTH):0] count
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [INS_W-1:0] mem   [DEPTH];
   logic [PC_W-1:0]  pcmem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [PC_W-1:0]  last_pc;
   logic             push, pop;

   assign if_ready = (count != FULL);
   assign id_valid = (count != '0);
   assign push     = if_valid & if_ready;
   assign pop      = id_valid & ~hazard;

   // Pointers wrap naturally; flush overrides everything, including hazard.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         last_pc <= '0;
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         last_pc <= PC_plus_4;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            last_pc <= pcmem[rd_ptr];
         end
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // Storage is unreset; id_valid keeps stale slots off the ID side.
   always_ff @(posedge Clk) begin
      if (push && !flush) begin
         mem[wr_ptr]   <= if_ins;
         pcmem[wr_ptr] <= PC_plus_4;
      end
   end

   always_comb begin
      id_ins       = NOP;
      id_PC_plus_4 = last_pc;
      if (id_valid) begin
         id_ins       = mem[rd_ptr];
         id_PC_plus_4 = pcmem[rd_ptr];
      end
   end

   a_count_range: assert property (@(posedge Clk) disable iff (Rst) count <= FULL);

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Parametrised IF/ID decoupling stage, the successor to the single-entry IF/ID pipeline register.
- Holds up to DEPTH fetched instructions, each with its PC+4, in a circular queue. Fetch can keep running while decode is stalled by a hazard.
- A branch-taken or jump flush discards every buffered entry in one cycle.
- Presents a bubble (NOP) to ID whenever the queue is empty.

Parameters:
INS_W, 32, instruction width in bits
PC_W, 30, width of the PC+4 field (word address, PC[31:2])
DEPTH, 4, queue entries; power of two, >= 2
NOP, 0, instruction value driven to ID when no valid entry exists (INS_W bits)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous reset, active-high
if_valid  in  1  IF presents an instruction this cycle
if_ready  out  1  buffer can accept (not full)
if_ins  in  INS_W  fetched instruction
PC_plus_4  in  PC_W  PC+4 of the fetched instruction
flush  in  1  branch taken or jump resolved; discard all entries
hazard  in  1  ID stalled (load-use etc.); head entry must not advance
id_ins  out  INS_W  head instruction, or NOP when empty
id_PC_plus_4  out  PC_W  PC+4 of the head instruction
id_valid  out  1  head entry is a real instruction
count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

Behaviour:
- Reset (async, immediate):
  - rd_ptr = wr_ptr = 0, count = 0, id_valid = 0, id_ins = NOP.
  - Last-PC register = 0, so id_PC_plus_4 = 0.
  - Storage contents are don't-care.
- Define push = if_valid & if_ready. Define pop = id_valid & ~hazard.
- if_ready = (count != DEPTH). It depends only on registered state: no combinational path from hazard or flush.
- Output mux, from registered state:
  - count > 0: id_ins = mem[rd_ptr], id_PC_plus_4 = pcmem[rd_ptr], id_valid = 1.
  - count == 0: id_ins = NOP, id_valid = 0, id_PC_plus_4 = last-PC register.
- Latency:
  - An entry pushed at edge N into an empty queue appears on id_* after edge N, i.e. one cycle, identical to a plain pipeline register.
  - With k entries ahead of it, it appears after the k-th subsequent pop.
- Normal cycle with flush = 0:
  - push writes mem[wr_ptr] and pcmem[wr_ptr]; wr_ptr advances.
  - pop advances rd_ptr; the popped entry's PC+4 is copied into the last-PC register.
  - count changes by push - pop; push and pop together leave count unchanged.
- Pointers wrap modulo DEPTH (natural overflow of $clog2(DEPTH)-bit counters).
- Full (count == DEPTH): if_ready = 0, so no push. A pop the same cycle frees a slot usable from the next cycle.
- Empty: pop cannot occur and hazard has no effect. A push into an empty queue while hazard = 1 is still stored.
- Hazard with count > 0: head entry held; id_ins and id_PC_plus_4 stable across the stall.
- Flush (synchronous, highest priority):
  - Sets rd_ptr = wr_ptr = 0 and count = 0, so id_valid = 0 and id_ins = NOP the next cycle.
  - A same-cycle push is discarded: the instruction is on the wrong path.
  - The last-PC register loads PC_plus_4 from the same cycle, so id_PC_plus_4 shows the fetch-side PC+4 after the flush.
  - hazard is ignored during a flush cycle.
- Storage is a plain register array with no reset. No read of an unwritten slot can reach id_* because id_valid gates the mux.
- Assertion for verification: count never exceeds DEPTH and never underflows.

Test Plan:
- Reset then idle, DEPTH=4: Rst pulse, if_valid=0 for 3 cycles -> id_valid=0, id_ins=0, id_PC_plus_4=0, count=0, if_ready=1.
- Streaming, hazard=0: push 0x8C010004 with PC_plus_4=1 at edge 1, then 0x00221820 with 2 at edge 2 -> id_ins shows 0x8C010004 / 1 after edge 1 and 0x00221820 / 2 after edge 2; count stays 1.
- Fill under stall: hazard=1 for 5 cycles while pushing A,B,C,D,E -> count reaches 4, if_ready=0 in the 5th cycle and E is not accepted, id_ins=A throughout. Release hazard -> A,B,C,D emerge on consecutive cycles, then id_valid=0.
- Flush with entries: count=3, flush=1 with if_valid=1, PC_plus_4=0x40 -> next cycle count=0, id_valid=0, id_ins=NOP, id_PC_plus_4=0x40; the same-cycle push is dropped.
- Wrap-around with simultaneous push/pop: DEPTH=2, 10 back-to-back instructions with hazard toggling every other cycle -> output order matches input order, no duplicates or losses, count never exceeds 2.
- Async reset mid-operation: Rst asserted between edges with count=3 -> id_valid=0 and count=0 immediately, before the next edge; the first push after release appears after one edge.
